// File: rtl/clic_lite_pkg.sv
// Shared types for the CLIC-lite interrupt source block:
// per-line configuration record and handshake FSM states.
package clic_lite_pkg;

    typedef struct packed {
        logic       ie;
        logic       edge_trig;
        logic [7:0] level;
        logic [1:0] priv;
        logic       shv;
    } irq_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        KILL
    } clic_state_e;

endpackage

// File: rtl/clic_lite_arb.sv
// Combinational max-tree arbiter: highest level wins, ties go to highest id.
// Ports: elig/level per line in; win_valid/win_id/win_level out.
module clic_lite_arb #(
    parameter int unsigned NumIrq   = 64,
    parameter int unsigned IdWidth  = $clog2(NumIrq),
    parameter int unsigned LvlWidth = 8
) (
    input  logic [NumIrq-1:0]               elig,
    input  logic [NumIrq-1:0][LvlWidth-1:0] level,
    output logic                            win_valid,
    output logic [IdWidth-1:0]              win_id,
    output logic [LvlWidth-1:0]             win_level
);

    localparam int unsigned Leaves = 1 << IdWidth;

    typedef struct packed {
        logic                valid;
        logic [LvlWidth-1:0] level;
        logic [IdWidth-1:0]  id;
    } cand_t;

    // hi always carries the larger id, so >= resolves ties toward it
    function automatic cand_t pick(cand_t lo, cand_t hi);
        if (hi.valid && (!lo.valid || hi.level >= lo.level)) return hi;
        return lo;
    endfunction

    for (genvar l = 0; l <= IdWidth; l++) begin : g_lvl
        localparam int unsigned W = Leaves >> l;
        cand_t node [W];
        for (genvar i = 0; i < W; i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < NumIrq) begin : g_real
                    assign node[i] = {elig[i], level[i], IdWidth'(i)};
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end else begin : g_max
                assign node[i] = pick(g_lvl[l-1].node[2*i],
                                      g_lvl[l-1].node[2*i+1]);
            end
        end
    end

    assign win_valid = g_lvl[IdWidth].node[0].valid;
    assign win_id    = g_lvl[IdWidth].node[0].id;
    assign win_level = g_lvl[IdWidth].node[0].level;

endmodule

// File: rtl/cva6_clic_lite.sv
// CLIC-lite interrupt source: per-line cfg/pending, level arbitration,
// clic_irq valid/ready presentation and clic_kill req/ack withdrawal.
module cva6_clic_lite
    import clic_lite_pkg::*;
#(
    parameter int unsigned NumIrq   = 64,
    parameter int unsigned IdWidth  = $clog2(NumIrq),
    parameter int unsigned LvlWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumIrq-1:0]   irq_src_i,
    input  logic [LvlWidth-1:0] thresh_i,
    input  logic                cfg_we_i,
    input  logic [IdWidth-1:0]  cfg_id_i,
    input  irq_cfg_t            cfg_i,
    input  logic                cfg_clr_pend_i,
    output logic                clic_irq_valid_o,
    input  logic                clic_irq_ready_i,
    output logic [IdWidth-1:0]  clic_irq_id_o,
    output logic [LvlWidth-1:0] clic_irq_level_o,
    output logic [1:0]          clic_irq_priv_o,
    output logic                clic_irq_shv_o,
    output logic                clic_kill_req_o,
    input  logic                clic_kill_ack_i
);

    irq_cfg_t                    cfg_q [NumIrq];
    logic [NumIrq-1:0]           src_q, pend_q;
    logic [NumIrq-1:0]           elig, set, clr;
    logic [NumIrq-1:0][LvlWidth-1:0] lvl;
    clic_state_e                 state_q;
    logic                        win_valid;
    logic [IdWidth-1:0]          win_id;
    logic [LvlWidth-1:0]         win_level;
    logic                        accept, kill;

    assign accept = (state_q == PRESENT) && clic_irq_ready_i;

    always_comb begin
        elig = '0;
        set  = '0;
        clr  = '0;
        lvl  = '0;
        for (int i = 0; i < NumIrq; i++) begin
            lvl[i]  = cfg_q[i].level;
            elig[i] = pend_q[i] && cfg_q[i].ie && (cfg_q[i].level > thresh_i);
            set[i]  = irq_src_i[i] && !src_q[i];
            clr[i]  = (accept && clic_irq_id_o == IdWidth'(i))
                   || (cfg_we_i && cfg_clr_pend_i && cfg_id_i == IdWidth'(i));
        end
    end

    // Withdraw if the presented line lost eligibility or is outranked
    assign kill = !elig[clic_irq_id_o]
               || (win_valid && win_level > clic_irq_level_o);

    clic_lite_arb #(
        .NumIrq  (NumIrq),
        .IdWidth (IdWidth),
        .LvlWidth(LvlWidth)
    ) i_arb (
        .elig     (elig),
        .level    (lvl),
        .win_valid(win_valid),
        .win_id   (win_id),
        .win_level(win_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIrq; i++) cfg_q[i] <= '0;
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q <= irq_src_i;
            if (cfg_we_i) cfg_q[cfg_id_i] <= cfg_i;
            for (int i = 0; i < NumIrq; i++) begin
                if (cfg_q[i].edge_trig)
                    pend_q[i] <= set[i] || (pend_q[i] && !clr[i]);
                else
                    pend_q[i] <= src_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            clic_irq_valid_o <= 1'b0;
            clic_irq_id_o    <= '0;
            clic_irq_level_o <= '0;
            clic_irq_priv_o  <= '0;
            clic_irq_shv_o   <= 1'b0;
            clic_kill_req_o  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        clic_irq_valid_o <= 1'b1;
                        clic_irq_id_o    <= win_id;
                        clic_irq_level_o <= win_level;
                        clic_irq_priv_o  <= cfg_q[win_id].priv;
                        clic_irq_shv_o   <= cfg_q[win_id].shv;
                        state_q          <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (clic_irq_ready_i) begin
                        clic_irq_valid_o <= 1'b0;
                        state_q          <= IDLE;
                    end else if (kill) begin
                        clic_irq_valid_o <= 1'b0;
                        clic_kill_req_o  <= 1'b1;
                        state_q          <= KILL;
                    end
                end
                KILL: begin
                    if (clic_kill_ack_i) begin
                        clic_kill_req_o <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_clic_lite.sv
// Directed bench for cva6_clic_lite: arbitration table plus
// handshake sequences (accept, preempt, ready-wins, withdraw, reset, sweep).
module tb_cva6_clic_lite;
    import clic_lite_pkg::*;

    logic        clk = 0;
    logic        rst_n;
    logic [63:0] irq_src;
    logic [7:0]  thresh;
    logic        cfg_we;
    logic [5:0]  cfg_id;
    irq_cfg_t    cfg;
    logic        cfg_clr;
    logic        valid, ready, kill_req, kill_ack, shv;
    logic [5:0]  id;
    logic [7:0]  level;
    logic [1:0]  priv;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cva6_clic_lite dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .irq_src_i       (irq_src),
        .thresh_i        (thresh),
        .cfg_we_i        (cfg_we),
        .cfg_id_i        (cfg_id),
        .cfg_i           (cfg),
        .cfg_clr_pend_i  (cfg_clr),
        .clic_irq_valid_o(valid),
        .clic_irq_ready_i(ready),
        .clic_irq_id_o   (id),
        .clic_irq_level_o(level),
        .clic_irq_priv_o (priv),
        .clic_irq_shv_o  (shv),
        .clic_kill_req_o (kill_req),
        .clic_kill_ack_i (kill_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n    = 0;
        irq_src  = '0;
        thresh   = '0;
        cfg_we   = 0;
        cfg_id   = '0;
        cfg      = '0;
        cfg_clr  = 0;
        ready    = 0;
        kill_ack = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic cfg_write(int i, bit ie, bit edg, int lv, int pv, bit sh);
        cfg_we = 1;
        cfg_id = 6'(i);
        cfg    = '{ie: ie, edge_trig: edg, level: 8'(lv),
                   priv: 2'(pv), shv: sh};
        tick();
        cfg_we = 0;
    endtask

    task automatic pulse(logic [63:0] m);
        irq_src = m;
        tick();
        irq_src = '0;
    endtask

    task automatic accept();
        ready = 1;
        tick();
        ready = 0;
    endtask

    typedef struct {
        int a, la, b, lb, thr;
        bit v1; int id1, lv1;
        bit v2; int id2;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{2, 7, 9, 7, 0, 1, 9, 7, 1, 2};
        vecs[1] = '{3, 5, 4, 6, 0, 1, 4, 6, 1, 3};
        vecs[2] = '{10, 0, 11, 0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{2, 7, 9, 7, 7, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 8, 60, 3, 7, 1, 1, 8, 0, 0};
        vecs[5] = '{63, 255, 0, 254, 0, 1, 63, 255, 1, 0};
        vecs[6] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0};

        // reset state and basic accept
        reset_dut();
        chk("rst_valid", valid, 0);
        chk("rst_kill", kill_req, 0);
        chk("rst_id", id, 0);
        chk("rst_level", level, 0);
        chk("rst_priv", priv, 0);
        cfg_write(3, 1, 1, 5, 3, 1);
        pulse(64'd1 << 3);
        chk("lat_early", valid, 0);
        tick();
        chk("basic_valid", valid, 1);
        chk("basic_id", id, 3);
        chk("basic_level", level, 5);
        chk("basic_priv", priv, 3);
        chk("basic_shv", shv, 1);
        accept();
        chk("basic_drop", valid, 0);
        chk("basic_pend", dut.pend_q[3], 0);

        // arbitration table
        foreach (vecs[k]) begin
            reset_dut();
            thresh = 8'(vecs[k].thr);
            cfg_write(vecs[k].a, 1, 1, vecs[k].la, 0, 0);
            cfg_write(vecs[k].b, 1, 1, vecs[k].lb, 0, 0);
            pulse((64'd1 << vecs[k].a) | (64'd1 << vecs[k].b));
            tick();
            chk($sformatf("v%0d_valid1", k), valid, 32'(vecs[k].v1));
            if (vecs[k].v1) begin
                chk($sformatf("v%0d_id1", k), id, vecs[k].id1);
                chk($sformatf("v%0d_lv1", k), level, vecs[k].lv1);
                accept();
                chk($sformatf("v%0d_drop", k), valid, 0);
                tick();
                chk($sformatf("v%0d_valid2", k), valid, 32'(vecs[k].v2));
                if (vecs[k].v2)
                    chk($sformatf("v%0d_id2", k), id, vecs[k].id2);
            end else begin
                tick();
                tick();
                chk($sformatf("v%0d_still0", k), valid, 0);
            end
        end

        // preemption by higher level
        reset_dut();
        cfg_write(4, 1, 1, 3, 0, 0);
        cfg_write(10, 1, 1, 200, 0, 0);
        pulse(64'd1 << 4);
        tick();
        chk("pre_id4", id, 4);
        pulse(64'd1 << 10);
        chk("pre_hold", valid, 1);
        tick();
        chk("pre_killreq", kill_req, 1);
        chk("pre_valid0", valid, 0);
        tick();
        tick();
        tick();
        chk("pre_killhold", kill_req, 1);
        kill_ack = 1;
        tick();
        kill_ack = 0;
        chk("pre_killdone", kill_req, 0);
        chk("pre_idle_gap", valid, 0);
        tick();
        chk("pre_valid10", valid, 1);
        chk("pre_id10", id, 10);
        chk("pre_lv10", level, 200);
        chk("pre_pend4", dut.pend_q[4], 1);

        // ready beats kill in the same cycle
        reset_dut();
        cfg_write(4, 1, 1, 3, 0, 0);
        cfg_write(10, 1, 1, 200, 0, 0);
        pulse(64'd1 << 4);
        tick();
        pulse(64'd1 << 10);
        accept();
        chk("rw_nokill", kill_req, 0);
        chk("rw_drop", valid, 0);
        chk("rw_pend4", dut.pend_q[4], 0);
        tick();
        chk("rw_valid", valid, 1);
        chk("rw_id10", id, 10);

        // level line withdrawn
        reset_dut();
        cfg_write(5, 1, 0, 9, 0, 0);
        irq_src = 64'd1 << 5;
        tick();
        tick();
        tick();
        chk("wd_valid", valid, 1);
        chk("wd_id", id, 5);
        irq_src = '0;
        tick();
        tick();
        tick();
        chk("wd_killreq", kill_req, 1);
        chk("wd_valid0", valid, 0);
        kill_ack = 1;
        tick();
        kill_ack = 0;
        chk("wd_killdone", kill_req, 0);
        tick();
        tick();
        chk("wd_norepresent", valid, 0);

        // edge set beats clear-pending
        reset_dut();
        thresh = 8'd255;
        cfg_write(6, 1, 1, 4, 0, 0);
        irq_src = 64'd1 << 6;
        cfg_we  = 1;
        cfg_clr = 1;
        cfg_id  = 6'd6;
        tick();
        irq_src = '0;
        cfg_we  = 0;
        cfg_clr = 0;
        chk("setwins_pend", dut.pend_q[6], 1);
        cfg_we  = 1;
        cfg_clr = 1;
        tick();
        cfg_we  = 0;
        cfg_clr = 0;
        chk("clr_pend", dut.pend_q[6], 0);

        // async reset while in KILL
        reset_dut();
        cfg_write(4, 1, 1, 3, 0, 0);
        cfg_write(10, 1, 1, 200, 0, 0);
        pulse(64'd1 << 4);
        tick();
        pulse(64'd1 << 10);
        tick();
        chk("rk_inkill", kill_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rk_kill0", kill_req, 0);
        chk("rk_valid0", valid, 0);
        chk("rk_id0", id, 0);
        chk("rk_level0", level, 0);
        tick();
        rst_n = 1;
        tick();
        tick();
        chk("rk_idle", valid, 0);

        // all 64 lines at once, distinct permuted levels
        reset_dut();
        for (int i = 0; i < 64; i++)
            cfg_write(i, 1, 1, ((i * 37) % 64) * 3 + 10, 0, 0);
        pulse('1);
        for (int k = 0; k < 64; k++) begin
            int exp_id;
            exp_id = 0;
            for (int j = 0; j < 64; j++)
                if ((j * 37) % 64 == 63 - k) exp_id = j;
            for (int w = 0; w < 4 && !valid; w++) tick();
            chk($sformatf("sw%0d_valid", k), valid, 1);
            chk($sformatf("sw%0d_level", k), level, (63 - k) * 3 + 10);
            chk($sformatf("sw%0d_id", k), id, exp_id);
            accept();
        end
        tick();
        tick();
        chk("sw_empty", valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
